// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned DEF_ADDR_W       = 32;
  localparam int unsigned DEF_DATA_W       = 32;
  localparam int unsigned DEF_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    CPU  = 2'd1,
    DBG  = 2'd2
  } owner_e;

endpackage

// File: rtl/dmem_arb_perf.sv
// Free-running wrap-around event counters for the arbiter (DMEM_ARB_PERF_EN builds only).
module dmem_arb_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        conflict,
  input  logic        dbg_win,
  output logic [31:0] conflict_cnt,
  output logic [31:0] dbg_cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= '0;
      dbg_cnt      <= '0;
    end else begin
      if (conflict) conflict_cnt <= 32'(conflict_cnt + 32'd1);
      if (dbg_win)  dbg_cnt      <= 32'(dbg_cnt + 32'd1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (CPU / debug) arbiter onto a single data memory with starvation relief for debug.
// Optional perf counters are built when DMEM_ARB_PERF_EN is defined.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_be,
  output logic                cpu_gnt,
  output logic                cpu_rvalid,
  output logic [DATA_W-1:0]   cpu_rdata,
  input  logic                dbg_req,
  input  logic                dbg_we,
  input  logic [ADDR_W-1:0]   dbg_addr,
  input  logic [DATA_W-1:0]   dbg_wdata,
  input  logic [DATA_W/8-1:0] dbg_be,
  output logic                dbg_gnt,
  output logic                dbg_rvalid,
  output logic [DATA_W-1:0]   dbg_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]         perf_conflict_cnt,
  output logic [31:0]         perf_dbg_cnt
`endif
);

  localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);

  logic [SC_W-1:0] starve_cnt;
  owner_e          rd_owner;
  logic            starved;

  // Debug takes the port once it has lost STARVE_LIMIT consecutive conflicts.
  assign starved = dbg_req && (starve_cnt == SC_W'(STARVE_LIMIT));
  assign cpu_gnt = !rst && cpu_req && !starved;
  assign dbg_gnt = !rst && dbg_req && !cpu_gnt;

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (cpu_gnt) begin
      mem_req   = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_be    = cpu_be;
    end else if (dbg_gnt) begin
      mem_req   = 1'b1;
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_be    = dbg_be;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      rd_owner   <= NONE;
    end else begin
      if (!dbg_req || dbg_gnt)
        starve_cnt <= '0;
      else if (cpu_gnt && (starve_cnt != SC_W'(STARVE_LIMIT)))
        starve_cnt <= starve_cnt + SC_W'(1);

      // Memory returns read data one cycle later; remember who it belongs to.
      if (cpu_gnt && !cpu_we)
        rd_owner <= CPU;
      else if (dbg_gnt && !dbg_we)
        rd_owner <= DBG;
      else
        rd_owner <= NONE;
    end
  end

  assign cpu_rvalid = (rd_owner == CPU);
  assign dbg_rvalid = (rd_owner == DBG);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

`ifdef DMEM_ARB_PERF_EN
  dmem_arb_perf u_perf (
    .clk          (clk),
    .rst          (rst),
    .conflict     (cpu_req && dbg_req),
    .dbg_win      (dbg_gnt),
    .conflict_cnt (perf_conflict_cnt),
    .dbg_cnt      (perf_dbg_cnt)
  );
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter with an in-bench reference model and DMEM.
module tb_dmem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 0, cpu_we = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0;
  logic [3:0]  cpu_be = 0;
  logic        dbg_req = 0, dbg_we = 0;
  logic [31:0] dbg_addr = 0, dbg_wdata = 0;
  logic [3:0]  dbg_be = 0;
  logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [31:0] cpu_rdata, dbg_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = 0;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_conflict_cnt, perf_dbg_cnt;
`endif

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_be(cpu_be), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_be(dbg_be), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    , .perf_conflict_cnt(perf_conflict_cnt), .perf_dbg_cnt(perf_dbg_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_val(input int i);
    case (i)
      0:       return 32'h0A0A_0000;
      1:       return 32'h0B0B_0004;
      4:       return 32'h0000_1234;
      default: return (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // DMEM: one-cycle read latency, byte-enabled writes.
  logic [31:0] dmem [16];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) dmem[i] <= init_val(i);
    end else if (mem_req) begin
      if (mem_we) dmem[mem_addr[5:2]] <= merge(dmem[mem_addr[5:2]], mem_wdata, mem_be);
      else        mem_rdata <= dmem[mem_addr[5:2]];
    end
  end

  // Reference model: who wins, what memory holds, and which read is due next cycle.
  logic [31:0] ref_mem [16];
  int          lost_run;
  int          pend_own;
  logic [31:0] pend_data;
  bit          cpu_won_last, dbg_won_last;
  logic        m_cg, m_dg;

  assign m_cg = cpu_req && !(dbg_req && lost_run == LIMIT);
  assign m_dg = dbg_req && !m_cg;

  always @(posedge clk) begin
    if (rst) begin
      lost_run <= 0; pend_own <= 0; pend_data <= 0;
      cpu_won_last <= 0; dbg_won_last <= 0;
      for (int i = 0; i < 16; i++) ref_mem[i] <= init_val(i);
    end else begin
      lost_run <= (dbg_req && m_cg) ? ((lost_run < LIMIT) ? lost_run + 1 : LIMIT) : 0;
      if (m_cg) begin
        if (cpu_we) ref_mem[cpu_addr[5:2]] <= merge(ref_mem[cpu_addr[5:2]], cpu_wdata, cpu_be);
        pend_own  <= cpu_we ? 0 : 1;
        pend_data <= ref_mem[cpu_addr[5:2]];
      end else if (m_dg) begin
        if (dbg_we) ref_mem[dbg_addr[5:2]] <= merge(ref_mem[dbg_addr[5:2]], dbg_wdata, dbg_be);
        pend_own  <= dbg_we ? 0 : 2;
        pend_data <= ref_mem[dbg_addr[5:2]];
      end else begin
        pend_own <= 0;
      end
      cpu_won_last <= m_cg;
      dbg_won_last <= m_dg;
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      if (rst) begin
        chk("rst_ctl", {26'd0, cpu_gnt, dbg_gnt, mem_req, mem_we, cpu_rvalid, dbg_rvalid}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        chk("rst_rdata", cpu_rdata | dbg_rdata, 32'd0);
      end else begin
        chk("cpu_gnt", 32'(cpu_gnt), 32'(m_cg));
        chk("dbg_gnt", 32'(dbg_gnt), 32'(m_dg));
        chk("mem_req", 32'(mem_req), 32'(m_cg | m_dg));
        chk("mem_we", 32'(mem_we), 32'(m_cg ? cpu_we : (m_dg ? dbg_we : 1'b0)));
        chk("mem_addr", mem_addr, m_cg ? cpu_addr : (m_dg ? dbg_addr : 32'd0));
        chk("mem_wdata", mem_wdata, m_cg ? cpu_wdata : (m_dg ? dbg_wdata : 32'd0));
        chk("mem_be", 32'(mem_be), 32'(m_cg ? cpu_be : (m_dg ? dbg_be : 4'd0)));
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(pend_own == 1));
        chk("dbg_rvalid", 32'(dbg_rvalid), 32'(pend_own == 2));
        chk("cpu_rdata", cpu_rdata, (pend_own == 1) ? pend_data : 32'd0);
        chk("dbg_rdata", dbg_rdata, (pend_own == 2) ? pend_data : 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  logic [5:0]  cpu_pat, dbg_pat;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] c0, d0;
`endif

  initial begin
    repeat (3) step();
    @(negedge clk);
    chk("reset_gnt", {30'd0, cpu_gnt, dbg_gnt}, 32'd0);

    // CPU-only read; the first grant lands in the first cycle out of reset.
    step();
    rst = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    @(negedge clk);
    chk("s1_gnt", 32'(cpu_gnt), 32'd1);
    chk("s1_addr", mem_addr, 32'h10);
    step(); cpu_req = 0;
    @(negedge clk);
    chk("s1_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("s1_rdata", cpu_rdata, 32'h1234);
    chk("s1_dbg_rvalid", 32'(dbg_rvalid), 32'd0);

    // Debug write, then CPU reads it back.
    step();
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h20; dbg_wdata = 32'hCAFE; dbg_be = 4'hF;
    @(negedge clk);
    chk("s2_gnt", 32'(dbg_gnt), 32'd1);
    chk("s2_we", 32'(mem_we), 32'd1);
    chk("s2_addr", mem_addr, 32'h20);
    chk("s2_wdata", mem_wdata, 32'hCAFE);
    step(); dbg_req = 0; dbg_we = 0; cpu_req = 1; cpu_addr = 32'h20;
    @(negedge clk);
    chk("s2_no_rvalid", {30'd0, cpu_rvalid, dbg_rvalid}, 32'd0);
    step(); cpu_req = 0;
    @(negedge clk);
    chk("s2_readback", cpu_rdata, 32'hCAFE);

    // Starvation: both held, debug wins on the fifth cycle only.
    step();
    cpu_req = 1; cpu_addr = 32'h0; dbg_req = 1; dbg_we = 0; dbg_addr = 32'h4;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      cpu_pat[c] = cpu_gnt;
      dbg_pat[c] = dbg_gnt;
      step();
    end
    chk("s3_cpu_pat", 32'(cpu_pat), 32'b101111);
    chk("s3_dbg_pat", 32'(dbg_pat), 32'b010000);
    cpu_req = 0; dbg_req = 0;

    // Interleaved reads: each owner gets its own data.
    step();
    cpu_req = 1; cpu_addr = 32'h0;
    @(negedge clk);
    chk("s4_cgnt", 32'(cpu_gnt), 32'd1);
    step(); cpu_req = 0; dbg_req = 1; dbg_addr = 32'h4;
    @(negedge clk);
    chk("s4_cpu_rdata", cpu_rdata, 32'h0A0A_0000);
    chk("s4_dgnt", 32'(dbg_gnt), 32'd1);
    step(); dbg_req = 0;
    @(negedge clk);
    chk("s4_dbg_rvalid", 32'(dbg_rvalid), 32'd1);
    chk("s4_dbg_rdata", dbg_rdata, 32'h0B0B_0004);
    chk("s4_cpu_rvalid", 32'(cpu_rvalid), 32'd0);

    // Reset asserted in the middle of a granted read.
    step();
    cpu_req = 1; cpu_addr = 32'h10;
    @(negedge clk);
    chk("s5_gnt", 32'(cpu_gnt), 32'd1);
    #2; rst = 1; cpu_req = 0;
    #1;
    chk("s5_async_gnt", {30'd0, cpu_gnt, mem_req}, 32'd0);
    @(posedge clk); #1;
    chk("s5_rvalid_dropped", 32'(cpu_rvalid), 32'd0);
    step(); step();
    rst = 0;
    @(negedge clk);
    chk("s5_after_rst", 32'(cpu_rvalid), 32'd0);

`ifdef DMEM_ARB_PERF_EN
    step();
    c0 = perf_conflict_cnt; d0 = perf_dbg_cnt;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h8; dbg_req = 1; dbg_we = 0; dbg_addr = 32'hC;
    repeat (10) step();
    cpu_req = 0; dbg_req = 0;
    chk("perf_conflict", 32'(perf_conflict_cnt - c0), 32'd10);
    chk("perf_dbg", 32'(perf_dbg_cnt - d0), 32'd2);
`endif

    // Random traffic; each requester holds its request until it is granted.
    repeat (4000) begin
      step();
      if (!cpu_req || cpu_won_last) begin
        cpu_req   = ($urandom_range(0, 99) < 85);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        cpu_wdata = $urandom;
        cpu_be    = 4'($urandom_range(0, 15));
      end
      if (!dbg_req || dbg_won_last) begin
        dbg_req   = ($urandom_range(0, 99) < 50);
        dbg_we    = 1'($urandom_range(0, 1));
        dbg_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        dbg_wdata = $urandom;
        dbg_be    = 4'($urandom_range(0, 15));
      end
    end
    step();
    cpu_req = 0; dbg_req = 0;
    step();
    @(negedge clk);
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
